// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: command front-end for i2c_master.
// Queues single-byte host transactions in a small FIFO and issues them one at a time.
// Each attempt is a one-cycle m_start pulse, followed by tracking of m_busy and m_ack_error.
// A NACK is retried up to MAX_RETRY times, with GAP_CYCLES idle cycles before each retry.
// A shared timer aborts an attempt that hangs.
// One response at a time is returned on a valid/ready port.
// Optional build macro I2C_SEQ_STATS_EN adds saturating done/error counters;
// without it, stat_done and stat_err are tied to zero.
module i2c_cmd_sequencer #(
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned BUSY_TIMEOUT = 1024,
  parameter int unsigned GAP_CYCLES   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_addr,
  input  logic        cmd_rw,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [6:0]  rsp_addr,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        m_start,
  output logic [6:0]  m_addr,
  output logic        m_rw,
  output logic [7:0]  m_data_in,
  input  logic        m_busy,
  input  logic        m_ack_error,
  input  logic [7:0]  m_data_out,
  output logic        idle,
  output logic [15:0] stat_done,
  output logic [15:0] stat_err
);

  localparam int unsigned PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CW = $clog2(CMD_DEPTH + 1);
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0] FullCnt   = CW'(CMD_DEPTH);
  localparam logic [TW-1:0] TimerMax  = TW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] GapMax    = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]    RetryMax  = 3'(MAX_RETRY);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StIssue    = 3'd1;
  localparam logic [2:0] StWaitBusy = 3'd2;
  localparam logic [2:0] StWaitDone = 3'd3;
  localparam logic [2:0] StGap      = 3'd4;
  localparam logic [2:0] StResp     = 3'd5;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [6:0]    fifo_addr  [CMD_DEPTH];
  logic          fifo_rw    [CMD_DEPTH];
  logic [7:0]    fifo_wdata [CMD_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_empty, push, pop;

  logic [2:0]    state_q, state_d;
  logic          rsp_valid_q, rsp_valid_d;

  assign fifo_empty = (count_q == '0);
  // Derived from the registered count, so a pop while full does not open a slot that cycle.
  assign cmd_ready  = (count_q != FullCnt);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == StIdle) && !fifo_empty && !rsp_valid_q;

  // FIFO storage: written on push, no reset needed since count guards reads
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q]  <= cmd_addr;
      fifo_rw[wr_ptr_q]    <= cmd_rw;
      fifo_wdata[wr_ptr_q] <= cmd_wdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  logic [2:0]    retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [6:0]    work_addr_q, work_addr_d;
  logic          work_rw_q, work_rw_d;
  logic [7:0]    work_wdata_q, work_wdata_d;
  logic [7:0]    res_rdata_q, res_rdata_d;
  logic          res_err_q, res_err_d;
  logic          res_timeout_q, res_timeout_d;
  logic [6:0]    rsp_addr_q, rsp_addr_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic [TW-1:0] timer_inc;

  // Saturate so a busy edge at the last timer count cannot wrap the shared timer
  assign timer_inc = (timer_q == TimerMax) ? timer_q : timer_q + TW'(1);

  // Next-state and working-register updates
  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    timer_d       = timer_q;
    gap_d         = gap_q;
    work_addr_d   = work_addr_q;
    work_rw_d     = work_rw_q;
    work_wdata_d  = work_wdata_q;
    res_rdata_d   = res_rdata_q;
    res_err_d     = res_err_q;
    res_timeout_d = res_timeout_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          work_addr_d   = fifo_addr[rd_ptr_q];
          work_rw_d     = fifo_rw[rd_ptr_q];
          work_wdata_d  = fifo_wdata[rd_ptr_q];
          retry_d       = '0;
          res_rdata_d   = '0;
          res_err_d     = 1'b0;
          res_timeout_d = 1'b0;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (m_busy) begin
          timer_d = timer_inc;
          state_d = StWaitDone;
        end else if (timer_q == TimerMax) begin
          res_err_d     = 1'b1;
          res_timeout_d = 1'b1;
          state_d       = StResp;
        end else begin
          timer_d = timer_inc;
        end
      end
      StWaitDone: begin
        if (!m_busy) begin
          if (!m_ack_error) begin
            res_rdata_d = work_rw_q ? m_data_out : 8'h00;
            state_d     = StResp;
          end else if (retry_q < RetryMax) begin
            retry_d = retry_q + 3'd1;
            gap_d   = '0;
            state_d = StGap;
          end else begin
            res_err_d = 1'b1;
            state_d   = StResp;
          end
        end else if (timer_q == TimerMax) begin
          res_err_d     = 1'b1;
          res_timeout_d = 1'b1;
          state_d       = StResp;
        end else begin
          timer_d = timer_inc;
        end
      end
      StGap: begin
        if (gap_q == GapMax) state_d = StIssue;
        else                 gap_d   = gap_q + GW'(1);
      end
      StResp: begin
        // rsp_valid is known low here: IDLE never pops while a response is pending
        rsp_valid_d   = 1'b1;
        rsp_addr_d    = work_addr_q;
        rsp_rdata_d   = res_rdata_q;
        rsp_err_d     = res_err_q;
        rsp_timeout_d = res_timeout_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and response registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      retry_q       <= '0;
      timer_q       <= '0;
      gap_q         <= '0;
      work_addr_q   <= '0;
      work_rw_q     <= 1'b0;
      work_wdata_q  <= '0;
      res_rdata_q   <= '0;
      res_err_q     <= 1'b0;
      res_timeout_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      retry_q       <= retry_d;
      timer_q       <= timer_d;
      gap_q         <= gap_d;
      work_addr_q   <= work_addr_d;
      work_rw_q     <= work_rw_d;
      work_wdata_q  <= work_wdata_d;
      res_rdata_q   <= res_rdata_d;
      res_err_q     <= res_err_d;
      res_timeout_q <= res_timeout_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign m_start     = (state_q == StIssue);
  assign m_addr      = work_addr_q;
  assign m_rw        = work_rw_q;
  assign m_data_in   = work_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign idle        = fifo_empty && (state_q == StIdle) && !rsp_valid_q;

`ifdef I2C_SEQ_STATS_EN
  logic [15:0] stat_done_q, stat_err_q;

  // Saturating completion counters, bumped as each response is loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_done_q <= '0;
      stat_err_q  <= '0;
    end else if (state_q == StResp) begin
      if (res_err_q) begin
        if (stat_err_q != 16'hFFFF) stat_err_q <= stat_err_q + 16'd1;
      end else begin
        if (stat_done_q != 16'hFFFF) stat_done_q <= stat_done_q + 16'd1;
      end
    end
  end

  assign stat_done = stat_done_q;
  assign stat_err  = stat_err_q;
`else
  assign stat_done = '0;
  assign stat_err  = '0;
`endif

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer (default parameters).
// A small behavioural master answers m_start with a few busy cycles.
// Address 0x22 is NACKed; everything else is ACKed.
`timescale 1ns/1ps
module tb_i2c_cmd_sequencer;

  localparam int BT       = 1024;
  localparam int BUSY_LEN = 4;
`ifdef I2C_SEQ_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [6:0]  cmd_addr = '0;
  logic        cmd_rw = 1'b0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [6:0]  rsp_addr;
  logic [7:0]  rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        m_start, m_rw;
  logic [6:0]  m_addr;
  logic [7:0]  m_data_in;
  logic        m_busy = 1'b0, m_ack_error = 1'b0;
  logic [7:0]  m_data_out = 8'h00;
  logic        idle;
  logic [15:0] stat_done, stat_err;

  always #5 clk = ~clk;

  i2c_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_data_in(m_data_in),
    .m_busy(m_busy), .m_ack_error(m_ack_error), .m_data_out(m_data_out),
    .idle(idle), .stat_done(stat_done), .stat_err(stat_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural master: busy from the cycle after m_start for BUSY_LEN+... cycles.
  bit         dead = 1'b0;
  int         busy_len = BUSY_LEN;
  logic [6:0] tgt;
  initial begin
    forever begin
      @(negedge clk);
      if (m_start && !dead) begin
        tgt = m_addr;
        @(negedge clk);
        m_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        m_busy      = 1'b0;
        m_ack_error = (tgt == 7'h22);
        m_data_out  = 8'h3C;
      end
    end
  end

  // Start-pulse monitor
  int         start_cnt = 0;
  int         last_start_cyc = 0, prev_start_cyc = 0;
  logic [6:0] st_addr;
  logic       st_rw;
  logic [7:0] st_wdata;
  always @(negedge clk) begin
    if (m_start) begin
      start_cnt++;
      prev_start_cyc = last_start_cyc;
      last_start_cyc = cyc;
      st_addr  = m_addr;
      st_rw    = m_rw;
      st_wdata = m_data_in;
    end
  end

  int push_cyc = 0;
  int rsp_cyc = 0;

  task automatic push(input logic [6:0] a, input logic rw, input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_rw = rw; cmd_wdata = d;
    push_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    rsp_cyc = cyc;
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_m_start", m_start, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_stat_done", stat_done, 0);

    // Write with ACK. Start at push+2; busy drops at start+5, RESP at +6, rsp_valid at +7.
    s0 = start_cnt;
    push(7'h51, 1'b0, 8'hA5);
    wait_rsp("wr", 100);
    check("wr_starts", start_cnt - s0, 1);
    check("wr_latency", last_start_cyc - push_cyc, 2);
    check("wr_rsp_lat", rsp_cyc - last_start_cyc, BUSY_LEN + 3);
    check("wr_m_addr", st_addr, 7'h51);
    check("wr_m_rw", st_rw, 0);
    check("wr_m_data_in", st_wdata, 8'hA5);
    check("wr_rsp_addr", rsp_addr, 7'h51);
    check("wr_rsp_rdata", rsp_rdata, 8'h00);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_timeout", rsp_timeout, 0);
    repeat (3) @(negedge clk);
    check("wr_rsp_hold", rsp_valid, 1);
    check("wr_idle_pending", idle, 0);
    accept();
    check("wr_rsp_cleared", rsp_valid, 0);
    check("wr_idle", idle, 1);

    // Read
    push(7'h51, 1'b1, 8'h00);
    wait_rsp("rd", 100);
    check("rd_m_rw", st_rw, 1);
    check("rd_rsp_rdata", rsp_rdata, 8'h3C);
    check("rd_rsp_err", rsp_err, 0);
    accept();

    // NACK retry: 3 attempts; start-to-start = 1 + 1 + BUSY_LEN busy + 8 gap
    s0 = start_cnt;
    push(7'h22, 1'b0, 8'h11);
    wait_rsp("nack", 300);
    check("nack_starts", start_cnt - s0, 3);
    check("nack_spacing", last_start_cyc - prev_start_cyc, BUSY_LEN + 10);
    check("nack_rsp_addr", rsp_addr, 7'h22);
    check("nack_rsp_err", rsp_err, 1);
    check("nack_rsp_timeout", rsp_timeout, 0);
    check("nack_rsp_rdata", rsp_rdata, 8'h00);
    accept();

    // Timeout: timer hits BT-1 BT cycles after m_start, then RESP, then rsp_valid
    dead = 1'b1;
    s0 = start_cnt;
    push(7'h40, 1'b1, 8'h00);
    wait_rsp("tmo", BT + 100);
    check("tmo_starts", start_cnt - s0, 1);
    check("tmo_rsp_lat", rsp_cyc - last_start_cyc, BT + 2);
    check("tmo_rsp_err", rsp_err, 1);
    check("tmo_rsp_timeout", rsp_timeout, 1);
    check("tmo_rsp_rdata", rsp_rdata, 8'h00);
    accept();
    dead = 1'b0;

    // FIFO full with response backpressure
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) push(7'h60 + 7'(i), 1'b0, 8'h80 + 8'(i));
    check("full_cmd_ready", cmd_ready, 0);
    push(7'h65, 1'b0, 8'hFF);  // dropped: FIFO full
    repeat (20) @(negedge clk);
    check("full_one_start", start_cnt - s0, 1);
    check("full_still_full", cmd_ready, 0);
    check("full_idle", idle, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!rsp_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("order_valid_%0d", i), rsp_valid, 1);
      check($sformatf("order_addr_%0d", i), rsp_addr, 7'h60 + 7'(i));
      check($sformatf("order_err_%0d", i), rsp_err, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    repeat (30) @(negedge clk);
    check("full_no_extra_rsp", rsp_valid, 0);
    check("full_starts", start_cnt - s0, 5);
    check("full_end_idle", idle, 1);
    check("stat_done", stat_done, StatsEn ? 7 : 0);
    check("stat_err", stat_err, StatsEn ? 2 : 0);

    // Reset mid-transfer during WAIT_DONE, with commands still queued
    busy_len = 30;
    s0 = start_cnt;
    push(7'h33, 1'b0, 8'h77);
    push(7'h34, 1'b0, 8'h78);
    push(7'h35, 1'b1, 8'h00);
    n = 0;
    while (!m_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("mid_busy", m_busy, 1);
    check("mid_started", start_cnt - s0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_rsp_valid", rsp_valid, 0);
    check("mrst_rsp_addr", rsp_addr, 0);
    check("mrst_rsp_rdata", rsp_rdata, 0);
    check("mrst_rsp_err", rsp_err, 0);
    check("mrst_rsp_timeout", rsp_timeout, 0);
    check("mrst_m_start", m_start, 0);
    check("mrst_m_addr", m_addr, 0);
    check("mrst_m_rw", m_rw, 0);
    check("mrst_m_data_in", m_data_in, 0);
    check("mrst_cmd_ready", cmd_ready, 1);
    check("mrst_idle", idle, 1);
    check("mrst_stat_done", stat_done, 0);
    check("mrst_stat_err", stat_err, 0);
    s0 = start_cnt;
    repeat (60) @(negedge clk);
    check("mrst_fifo_empty", start_cnt - s0, 0);
    check("mrst_no_rsp", rsp_valid, 0);
    check("mrst_idle_after", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
